// File: rtl/pc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pc_ctrl_pkg
// Shared types and constants for the bittyCore fetch-address controller.
//   pc_state_e      : controller state encoding (idle / run / wait)
//   PC_RESET_VECTOR : default first fetch address after reset
//   PC_ADDR_W       : default address width
//   PC_STEP         : sequential fetch increment in bytes
// -----------------------------------------------------------------------------
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        PC_IDLE = 2'd0,   // held while rst is asserted
        PC_RUN  = 2'd1,   // a request may be issued
        PC_WAIT = 2'd2    // request outstanding, not yet accepted
    } pc_state_e;

    localparam int          PC_ADDR_W       = 32;
    localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP         = 32'd4;

endpackage

// File: rtl/pc_redirect_arb.sv
// -----------------------------------------------------------------------------
// pc_redirect_arb
// Combinational priority select of the redirect request for the fetch
// controller. Priority: trap > mret > branch.
// Optional feature macro: BITTY_TRAP_EN (adds the trap and mret legs).
//
// Ports
//   branch_flag_i / branch_addr_i : taken branch or jump and its target
//   trap_flag_i   / trap_vec_i    : trap entry and vector (BITTY_TRAP_EN only)
//   mret_flag_i   / mepc_i        : mret and return address (BITTY_TRAP_EN only)
//   redir_flag_o  / redir_addr_o  : winning redirect request and target
// -----------------------------------------------------------------------------
module pc_redirect_arb
    import pc_ctrl_pkg::*;
#(
    parameter int ADDR_W = PC_ADDR_W
) (
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_addr_i,
`ifdef BITTY_TRAP_EN
    input  logic              trap_flag_i,
    input  logic [ADDR_W-1:0] trap_vec_i,
    input  logic              mret_flag_i,
    input  logic [ADDR_W-1:0] mepc_i,
`endif
    output logic              redir_flag_o,
    output logic [ADDR_W-1:0] redir_addr_o
);

    // Priority select of redirect flag and target.
    always_comb begin
        redir_flag_o = 1'b0;
        redir_addr_o = branch_addr_i;
`ifdef BITTY_TRAP_EN
        if (trap_flag_i) begin
            redir_flag_o = 1'b1;
            redir_addr_o = trap_vec_i;
        end else if (mret_flag_i) begin
            redir_flag_o = 1'b1;
            redir_addr_o = mepc_i;
        end else if (branch_flag_i) begin
            redir_flag_o = 1'b1;
            redir_addr_o = branch_addr_i;
        end else begin
            redir_flag_o = 1'b0;
            redir_addr_o = branch_addr_i;
        end
`else
        if (branch_flag_i) begin
            redir_flag_o = 1'b1;
            redir_addr_o = branch_addr_i;
        end else begin
            redir_flag_o = 1'b0;
            redir_addr_o = branch_addr_i;
        end
`endif
    end

endmodule

// File: rtl/pc_ctrl.sv
// -----------------------------------------------------------------------------
// pc_ctrl
// Fetch-address controller for the bittyCore front end. Owns the program
// counter, issues fetch requests with a req/ready handshake, arbitrates
// redirects against stall and sequential increment, and tags returning
// instructions valid or killed. All outputs are registered.
// Optional feature macro: BITTY_TRAP_EN (trap/mret redirect sources).
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   stall_i             : pipeline hazard hold, no new fetch issued
//   branch_flag_i/addr  : taken branch and target
//   trap_flag_i/vec_i   : trap entry and mtvec      (BITTY_TRAP_EN only)
//   mret_flag_i/mepc_i  : mret and return address   (BITTY_TRAP_EN only)
//   ibus_req_o/addr_o   : fetch request and address
//   ibus_ready_i        : bus accepts the request this cycle
//   if_valid_o/if_pc_o  : returned instruction usable, and its PC
//   flush_o             : one-cycle pulse per redirect taken
// -----------------------------------------------------------------------------
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int                ADDR_W     = PC_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(PC_RESET_VECTOR)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_addr_i,
`ifdef BITTY_TRAP_EN
    input  logic              trap_flag_i,
    input  logic [ADDR_W-1:0] trap_vec_i,
    input  logic              mret_flag_i,
    input  logic [ADDR_W-1:0] mepc_i,
`endif
    output logic              ibus_req_o,
    output logic [ADDR_W-1:0] ibus_addr_o,
    input  logic              ibus_ready_i,
    output logic              if_valid_o,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic              flush_o
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    pc_state_e         state_r, state_s;
    logic              req_r, req_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic              pend_valid_r, pend_valid_s;
    logic [ADDR_W-1:0] pend_addr_r, pend_addr_s;
    logic              if_valid_r, if_valid_s;
    logic [ADDR_W-1:0] if_pc_r, if_pc_s;
    logic              flush_r, flush_s;

    logic              redir_flag_s;
    logic [ADDR_W-1:0] redir_addr_s;
    logic              accept_s;

    pc_redirect_arb #(
        .ADDR_W (ADDR_W)
    ) u_arb (
        .branch_flag_i (branch_flag_i),
        .branch_addr_i (branch_addr_i),
`ifdef BITTY_TRAP_EN
        .trap_flag_i   (trap_flag_i),
        .trap_vec_i    (trap_vec_i),
        .mret_flag_i   (mret_flag_i),
        .mepc_i        (mepc_i),
`endif
        .redir_flag_o  (redir_flag_s),
        .redir_addr_o  (redir_addr_s)
    );

    assign accept_s = req_r & ibus_ready_i;

    // Next-state, next-address and return-tag logic.
    always_comb begin
        state_s      = state_r;
        req_s        = req_r;
        addr_s       = addr_r;
        pend_valid_s = pend_valid_r;
        pend_addr_s  = pend_addr_r;
        if_valid_s   = 1'b0;
        if_pc_s      = if_pc_r;
        flush_s      = 1'b0;
        case (state_r)
            PC_IDLE: begin
                // First cycle out of reset always fetches the reset vector.
                state_s      = PC_RUN;
                req_s        = 1'b1;
                addr_s       = RESET_ADDR;
                pend_valid_s = 1'b0;
            end
            PC_RUN, PC_WAIT: begin
                flush_s = redir_flag_s;
                if (accept_s) begin
                    // The accepted fetch is killed if a redirect is pending
                    // or lands on this same edge.
                    if_valid_s   = ~(pend_valid_r | redir_flag_s);
                    if_pc_s      = addr_r;
                    pend_valid_s = 1'b0;
                    state_s      = PC_RUN;
                    req_s        = ~stall_i;
                    if (pend_valid_r) begin
                        addr_s = pend_addr_r;
                    end else if (redir_flag_s) begin
                        addr_s = redir_addr_s;
                    end else if (stall_i) begin
                        addr_s = addr_r;
                    end else begin
                        addr_s = addr_r + STEP;
                    end
                end else if (req_r) begin
                    // Request outstanding: bus-facing outputs frozen, a
                    // redirect is parked until acceptance.
                    state_s = PC_WAIT;
                    if (redir_flag_s) begin
                        pend_valid_s = 1'b1;
                        pend_addr_s  = redir_addr_s;
                    end else begin
                        pend_valid_s = pend_valid_r;
                        pend_addr_s  = pend_addr_r;
                    end
                end else begin
                    // Stalled with nothing outstanding: a redirect still
                    // moves the PC, issue resumes once stall drops.
                    state_s = PC_RUN;
                    req_s   = ~stall_i;
                    if (redir_flag_s) begin
                        addr_s = redir_addr_s;
                    end else begin
                        addr_s = addr_r;
                    end
                end
            end
            default: begin
                state_s      = PC_IDLE;
                req_s        = 1'b0;
                addr_s       = RESET_ADDR;
                pend_valid_s = 1'b0;
            end
        endcase
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= PC_IDLE;
            req_r        <= 1'b0;
            addr_r       <= RESET_ADDR;
            pend_valid_r <= 1'b0;
            pend_addr_r  <= RESET_ADDR;
            if_valid_r   <= 1'b0;
            if_pc_r      <= '0;
            flush_r      <= 1'b0;
        end else begin
            state_r      <= state_s;
            req_r        <= req_s;
            addr_r       <= addr_s;
            pend_valid_r <= pend_valid_s;
            pend_addr_r  <= pend_addr_s;
            if_valid_r   <= if_valid_s;
            if_pc_r      <= if_pc_s;
            flush_r      <= flush_s;
        end
    end

    assign ibus_req_o  = req_r;
    assign ibus_addr_o = addr_r;
    assign if_valid_o  = if_valid_r;
    assign if_pc_o     = if_pc_r;
    assign flush_o     = flush_r;

endmodule

// File: tb/tb_pc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_ctrl
// Directed bench for pc_ctrl: reset, sequential fetch, branch kill, ready
// back-pressure with a parked redirect, redirect priority, stall/resume,
// address wrap and reset during an outstanding request.
// Works with and without BITTY_TRAP_EN.
// -----------------------------------------------------------------------------
module tb_pc_ctrl;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        branch_flag_i;
    logic [31:0] branch_addr_i;
`ifdef BITTY_TRAP_EN
    logic        trap_flag_i;
    logic [31:0] trap_vec_i;
    logic        mret_flag_i;
    logic [31:0] mepc_i;
`endif
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_ready_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic        flush_o;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] last_r;

    pc_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .branch_flag_i (branch_flag_i),
        .branch_addr_i (branch_addr_i),
`ifdef BITTY_TRAP_EN
        .trap_flag_i   (trap_flag_i),
        .trap_vec_i    (trap_vec_i),
        .mret_flag_i   (mret_flag_i),
        .mepc_i        (mepc_i),
`endif
        .ibus_req_o    (ibus_req_o),
        .ibus_addr_o   (ibus_addr_o),
        .ibus_ready_i  (ibus_ready_i),
        .if_valid_o    (if_valid_o),
        .if_pc_o       (if_pc_o),
        .flush_o       (flush_o)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic chk_out(input string tag, input logic req, input logic [31:0] addr,
                           input logic vld, input logic [31:0] pc, input logic fl);
        check({tag, ".req"},   {31'd0, ibus_req_o}, {31'd0, req});
        check({tag, ".addr"},  ibus_addr_o,         addr);
        check({tag, ".valid"}, {31'd0, if_valid_o}, {31'd0, vld});
        check({tag, ".pc"},    if_pc_o,             pc);
        check({tag, ".flush"}, {31'd0, flush_o},    {31'd0, fl});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic branch(input logic [31:0] tgt);
        branch_flag_i = 1'b1;
        branch_addr_i = tgt;
        tick();
        branch_flag_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall_i = 1'b0; ibus_ready_i = 1'b1;
        branch_flag_i = 1'b0; branch_addr_i = 32'd0;
`ifdef BITTY_TRAP_EN
        trap_flag_i = 1'b0; trap_vec_i = 32'd0;
        mret_flag_i = 1'b0; mepc_i = 32'd0;
`endif
        tick(); tick();
        chk_out("reset", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

        // Sequential fetch from the reset vector.
        rst = 1'b0;
        tick(); chk_out("boot", 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
        tick(); chk_out("seq4", 1'b1, 32'h4, 1'b1, 32'h0, 1'b0);
        tick(); chk_out("seq8", 1'b1, 32'h8, 1'b1, 32'h4, 1'b0);
        tick(); chk_out("seqC", 1'b1, 32'hC, 1'b1, 32'h8, 1'b0);

        // Branch kills the fetch of 0xC.
        branch(32'h100); chk_out("br100", 1'b1, 32'h100, 1'b0, 32'hC, 1'b1);
        tick();          chk_out("br100n", 1'b1, 32'h104, 1'b1, 32'h100, 1'b0);

        // ready low three edges at 0x10, branch to 0x200 parked meanwhile.
        branch(32'h10); ibus_ready_i = 1'b0;
        chk_out("br10", 1'b1, 32'h10, 1'b0, 32'h104, 1'b1);
        tick();          chk_out("wait1", 1'b1, 32'h10, 1'b0, 32'h104, 1'b0);
        branch(32'h200); chk_out("wait2", 1'b1, 32'h10, 1'b0, 32'h104, 1'b1);
        tick();          chk_out("wait3", 1'b1, 32'h10, 1'b0, 32'h104, 1'b0);
        ibus_ready_i = 1'b1;
        tick();          chk_out("pend", 1'b1, 32'h200, 1'b0, 32'h10, 1'b0);
        tick();          chk_out("pendn", 1'b1, 32'h204, 1'b1, 32'h200, 1'b0);

        // Same-cycle redirect priority.
`ifdef BITTY_TRAP_EN
        trap_flag_i = 1'b1; trap_vec_i = 32'h80;
        branch(32'h300); trap_flag_i = 1'b0;
        chk_out("prio_trap", 1'b1, 32'h80, 1'b0, 32'h204, 1'b1);
        mret_flag_i = 1'b1; mepc_i = 32'h600;
        branch(32'h700); mret_flag_i = 1'b0;
        chk_out("prio_mret", 1'b1, 32'h600, 1'b0, 32'h80, 1'b1);
        last_r = 32'h600;
`else
        branch(32'h300);
        chk_out("prio_br", 1'b1, 32'h300, 1'b0, 32'h204, 1'b1);
        last_r = 32'h300;
`endif
        tick(); chk_out("prio_n", 1'b1, last_r + 32'd4, 1'b1, last_r, 1'b0);

        // Stall two edges at 0x20, then resume at 0x20 and 0x24.
        branch(32'h20); chk_out("br20", 1'b1, 32'h20, 1'b0, last_r + 32'd4, 1'b1);
        stall_i = 1'b1;
        tick(); chk_out("stall1", 1'b0, 32'h20, 1'b1, 32'h20, 1'b0);
        tick(); chk_out("stall2", 1'b0, 32'h20, 1'b0, 32'h20, 1'b0);
        stall_i = 1'b0;
        tick(); chk_out("resume", 1'b1, 32'h20, 1'b0, 32'h20, 1'b0);
        tick(); chk_out("resume2", 1'b1, 32'h24, 1'b1, 32'h20, 1'b0);

        // Redirect while stalled moves the PC, issued when stall drops.
        stall_i = 1'b1;
        tick();          chk_out("stall3", 1'b0, 32'h24, 1'b1, 32'h24, 1'b0);
        branch(32'h400); chk_out("stall_br", 1'b0, 32'h400, 1'b0, 32'h24, 1'b1);
        stall_i = 1'b0;
        tick(); chk_out("stall_rs", 1'b1, 32'h400, 1'b0, 32'h24, 1'b0);
        tick(); chk_out("stall_rs2", 1'b1, 32'h404, 1'b1, 32'h400, 1'b0);

        // Address wrap.
        branch(32'hFFFF_FFFC); chk_out("br_wrap", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h404, 1'b1);
        tick(); chk_out("wrap", 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0);

        // Reset while a request is outstanding.
        branch(32'h500); chk_out("br500", 1'b1, 32'h500, 1'b0, 32'h0, 1'b1);
        ibus_ready_i = 1'b0;
        tick(); chk_out("wait500", 1'b1, 32'h500, 1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        tick(); chk_out("rst_wait", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        rst = 1'b0; ibus_ready_i = 1'b1;
        tick(); chk_out("reboot", 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
        tick(); chk_out("reboot4", 1'b1, 32'h4, 1'b1, 32'h0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
